// File: rtl/bram_arb_pkg.sv
// Shared types, widths and the round-robin pick helper
// for the BRAM port arbiter.
package bram_arb_pkg;

    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_WE_W   = 4;
    localparam int BRAM_ADDR_W = 32;
    localparam int MAX_REQ     = 8;
    localparam int IDX_W       = 3;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } arb_state_t;

    // First set bit of req at or above ptr, wrapping modulo n.
    // Returns ptr when nothing is set; callers only use the
    // result when at least one bit is set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        int j;
        rr_pick = ptr;
        // Walk downward so the closest candidate wins last.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (req[j[IDX_W-1:0]]) begin
                    rr_pick = j[IDX_W-1:0];
                end
            end
        end
    endfunction

endpackage

// File: rtl/bram_port_arb_if.sv
// Requester-side and memory-side buses of the BRAM port arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface bram_port_arb_if #(
    parameter int NUM_REQ = 4
);
    import bram_arb_pkg::*;

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*BRAM_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*BRAM_DATA_W-1:0] req_wrdata;
    logic [NUM_REQ*BRAM_WE_W-1:0]   req_we;
    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             rd_valid;
    logic [BRAM_DATA_W-1:0]         rd_data;

    logic [BRAM_ADDR_W-1:0]         BRAM_ADDR;
    logic [BRAM_DATA_W-1:0]         BRAM_WRDATA;
    logic [BRAM_WE_W-1:0]           BRAM_WE;
    logic                           BRAM_CLK;
    logic [BRAM_DATA_W-1:0]         BRAM_RDDATA;
    logic                           BRAM_EN;
    logic                           BRAM_RST;

    modport slave (
        input  req, req_addr, req_wrdata, req_we, BRAM_RDDATA,
        output gnt, rd_valid, rd_data,
        output BRAM_ADDR, BRAM_WRDATA, BRAM_WE,
        output BRAM_CLK, BRAM_EN, BRAM_RST
    );

    modport master (
        output req, req_addr, req_wrdata, req_we, BRAM_RDDATA,
        input  gnt, rd_valid, rd_data,
        input  BRAM_ADDR, BRAM_WRDATA, BRAM_WE,
        input  BRAM_CLK, BRAM_EN, BRAM_RST
    );

endinterface

// File: rtl/bram_rd_tag_pipe.sv
// RD_LAT-deep {valid, id} shift register that turns an issued read
// into a one-hot rd_valid strobe RD_LAT cycles later.
module bram_rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RD_LAT  = 2
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               issue,
    input  logic [IDX_W-1:0]   id,
    output logic [NUM_REQ-1:0] rd_valid
);

    logic [RD_LAT-1:0] vld;
    logic [IDX_W-1:0]  tag [RD_LAT];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag[s] <= '0;
            end
        end else begin
            vld[0] <= issue;
            tag[0] <= id;
            for (int s = 1; s < RD_LAT; s++) begin
                vld[s] <= vld[s-1];
                tag[s] <= tag[s-1];
            end
        end
    end

    assign rd_valid = vld[RD_LAT-1]
                    ? (NUM_REQ'(1) << tag[RD_LAT-1])
                    : '0;

endmodule

// File: rtl/bram_port_arb.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters.
// Ports: aclk, aresetn (async, active-low), bus (slave modport).
module bram_port_arb
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int RD_LAT          = 2,
    parameter int MAX_HOLD        = 64
) (
    input  logic           aclk,
    input  logic           aresetn,
    bram_port_arb_if.slave bus
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [BRAM_ADDR_W-1:0] ADDR_MASK =
        BRAM_ADDR_W'((64'd1 << BRAM_ADDR_WIDTH) - 64'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t             state, state_n;
    logic [IDX_W-1:0]       own, own_n;
    logic [IDX_W-1:0]       ptr, ptr_n;
    logic [HOLD_W-1:0]      hold, hold_n;
    logic [BRAM_ADDR_W-1:0] last_addr;
    logic [BRAM_DATA_W-1:0] last_wrdata;

    logic [NUM_REQ-1:0]     own_oh;
    logic [NUM_REQ-1:0]     others;
    logic [MAX_REQ-1:0]     req_ext;
    logic [MAX_REQ-1:0]     others_ext;
    logic                   own_req;
    logic                   hold_lim;
    logic                   access;
    logic                   rd_issue;
    logic [BRAM_ADDR_W-1:0] sel_addr;
    logic [BRAM_DATA_W-1:0] sel_wrdata;
    logic [BRAM_WE_W-1:0]   sel_we;

    function automatic logic [IDX_W-1:0] next_idx(
        input logic [IDX_W-1:0] i
    );
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Owner's slice of the requester buses.
    always_comb begin
        sel_addr   = '0;
        sel_wrdata = '0;
        sel_we     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own == IDX_W'(i)) begin
                sel_addr   = bus.req_addr[i*BRAM_ADDR_W +: BRAM_ADDR_W];
                sel_wrdata = bus.req_wrdata[i*BRAM_DATA_W +: BRAM_DATA_W];
                sel_we     = bus.req_we[i*BRAM_WE_W +: BRAM_WE_W];
            end
        end
    end

    assign own_oh     = NUM_REQ'(1) << own;
    assign own_req    = |(bus.req & own_oh);
    assign others     = bus.req & ~own_oh;
    assign req_ext    = MAX_REQ'(bus.req);
    assign others_ext = MAX_REQ'(others);
    assign hold_lim   = (MAX_HOLD != 0) && (hold == HOLD_LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            own         <= '0;
            ptr         <= '0;
            hold        <= '0;
            last_addr   <= '0;
            last_wrdata <= '0;
        end else begin
            state <= state_n;
            own   <= own_n;
            ptr   <= ptr_n;
            hold  <= hold_n;
            if (access) begin
                last_addr   <= sel_addr & ADDR_MASK;
                last_wrdata <= sel_wrdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        own_n   = own;
        ptr_n   = ptr;
        hold_n  = hold;
        unique case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_n = ST_OWN;
                    own_n   = rr_pick(req_ext, ptr, NUM_REQ);
                    hold_n  = '0;
                end
            end
            ST_OWN: begin
                // A voluntary drop and a hold-limit hit share one path.
                if (!own_req || (hold_lim && |others)) begin
                    ptr_n  = next_idx(own);
                    hold_n = '0;
                    if (|others) begin
                        own_n = rr_pick(others_ext, next_idx(own), NUM_REQ);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (!hold_lim) begin
                    // Saturates so a late waiter is served at once.
                    hold_n = hold + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        access          = (state == ST_OWN) && own_req;
        rd_issue        = access && (sel_we == '0);
        bus.gnt         = (state == ST_OWN) ? own_oh : '0;
        bus.BRAM_ADDR   = access ? (sel_addr & ADDR_MASK) : last_addr;
        bus.BRAM_WRDATA = access ? sel_wrdata : last_wrdata;
        bus.BRAM_WE     = access ? sel_we : '0;
    end

    assign bus.BRAM_CLK = aclk;
    assign bus.BRAM_EN  = 1'b1;
    assign bus.BRAM_RST = 1'b0;
    assign bus.rd_data  = bus.BRAM_RDDATA;

    bram_rd_tag_pipe #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT)
    ) u_tag_pipe (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .issue    (rd_issue),
        .id       (own),
        .rd_valid (bus.rd_valid)
    );

endmodule
